// File: rtl/mips_alu_pkg.sv
// Shared ALU control encodings and datapath width for the MIPS32 execute stage.
// Imported by the ALU, its shifter and the ALU control unit.
package mips_alu_pkg;
    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_XOR  = 4'b1101;
endpackage

// File: rtl/mips_alu_if.sv
// Operand/control and result/flag bundle between the execute stage and the ALU.
interface mips_alu_if;
    import mips_alu_pkg::*;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        ALU_Ctrl;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              overflow;

    modport master (output a, b, ALU_Ctrl, input result, zero, overflow);
    modport slave  (input a, b, ALU_Ctrl, output result, zero, overflow);
endinterface

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter for SLL/SRL/SRA; shift amount is b[4:0].
module alu_shifter
    import mips_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [4:0]        shamt,
    input  logic [3:0]        ctrl,
    output logic [DATA_W-1:0] y
);
    always_comb begin
        y = '0;
        case (ctrl)
            ALU_SLL: y = a << shamt;
            ALU_SRL: y = a >> shamt;
            ALU_SRA: y = DATA_W'($signed(a) >>> shamt);
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/mips_alu.sv
// Registered MIPS32 ALU: op mux, zero/overflow flags, one-cycle output register.
// Shift ops (SLL/SRL/SRA) are built only when MIPS_ALU_SHIFT_EN is defined.
module mips_alu
    import mips_alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mips_alu_if.slave  bus
);
    logic [DATA_W-1:0] sum, diff, nxt_result;
    logic              nxt_ovf;

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;

`ifdef MIPS_ALU_SHIFT_EN
    logic [DATA_W-1:0] shift_y;

    alu_shifter u_shifter (
        .a     (bus.a),
        .shamt (bus.b[4:0]),
        .ctrl  (bus.ALU_Ctrl),
        .y     (shift_y)
    );
`endif

    always_comb begin
        nxt_result = '0;
        nxt_ovf    = 1'b0;
        case (bus.ALU_Ctrl)
            ALU_AND:  nxt_result = bus.a & bus.b;
            ALU_OR:   nxt_result = bus.a | bus.b;
            ALU_ADD: begin
                nxt_result = sum;
                nxt_ovf    = (bus.a[DATA_W-1] == bus.b[DATA_W-1]) &&
                             (sum[DATA_W-1] != bus.a[DATA_W-1]);
            end
            ALU_SUB: begin
                nxt_result = diff;
                nxt_ovf    = (bus.a[DATA_W-1] != bus.b[DATA_W-1]) &&
                             (diff[DATA_W-1] != bus.a[DATA_W-1]);
            end
            // True comparisons, not the wrapped subtractor sign.
            ALU_SLT:  nxt_result = {{(DATA_W-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            ALU_SLTU: nxt_result = {{(DATA_W-1){1'b0}}, bus.a < bus.b};
            ALU_NOR:  nxt_result = ~(bus.a | bus.b);
            ALU_XOR:  nxt_result = bus.a ^ bus.b;
`ifdef MIPS_ALU_SHIFT_EN
            ALU_SLL, ALU_SRL, ALU_SRA: nxt_result = shift_y;
`endif
            default:  nxt_result = '0;
        endcase
    end

    // Zero flag comes from the value being registered, never the old result.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.result   <= '0;
            bus.zero     <= 1'b1;
            bus.overflow <= 1'b0;
        end else begin
            bus.result   <= nxt_result;
            bus.zero     <= ~|nxt_result;
            bus.overflow <= nxt_ovf;
        end
    end
endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed plan steps plus random ops vs a reference model.
module tb_mips_alu;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mips_alu_if bus ();

    mips_alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: {overflow, result} from plain 64-bit arithmetic on the spec rules.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        logic [31:0] res;
        logic        ov;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 32'd0;
        ov  = 1'b0;
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: begin r = sa + sb; res = r[31:0]; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'b0110: begin r = sa - sb; res = r[31:0]; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: res = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            4'b1100: res = ~(a | b);
            4'b1101: res = a ^ b;
`ifdef MIPS_ALU_SHIFT_EN
            4'b0011: res = a << b[4:0];
            4'b0100: res = a >> b[4:0];
            4'b0101: res = (a >> b[4:0]) | (a[31] ? ~(32'hFFFF_FFFF >> b[4:0]) : 32'd0);
`endif
            default: res = 32'd0;
        endcase
        return {ov, res};
    endfunction

    task automatic check(input string tag, input logic [31:0] er, input logic ez, input logic eo);
        checks++;
        assert (bus.result === er && bus.zero === ez && bus.overflow === eo)
        else begin
            errors++;
            $error("FAIL %s: got r=%h z=%b o=%b, exp r=%h z=%b o=%b",
                   tag, bus.result, bus.zero, bus.overflow, er, ez, eo);
        end
    endtask

    // Drive at negedge, check #1 after the posedge, then perturb inputs mid-cycle and recheck.
    task automatic step(input string tag, input logic rst, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        logic [32:0] m;
        logic [31:0] er;
        logic ez, eo;
        @(negedge clk);
        reset = rst; bus.ALU_Ctrl = op; bus.a = a; bus.b = b;
        m  = model(op, a, b);
        er = rst ? 32'd0 : m[31:0];
        eo = rst ? 1'b0  : m[32];
        ez = (er == 32'd0);
        @(posedge clk);
        #1;
        check(tag, er, ez, eo);
        bus.a = $urandom; bus.b = $urandom; bus.ALU_Ctrl = 4'($urandom);
        #2;
        check({tag, "_hold"}, er, ez, eo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        reset = 1'b1; bus.a = 32'd5; bus.b = 32'd3; bus.ALU_Ctrl = 4'b0010;

        step("reset0", 1'b1, 4'b0010, 32'd5, 32'd3);
        step("reset1", 1'b1, 4'b0010, 32'd5, 32'd3);

        step("add", 1'b0, 4'b0010, 32'd5, 32'd3);
        check("add_const", 32'd8, 1'b0, 1'b0);
        step("sub", 1'b0, 4'b0110, 32'd5, 32'd3);
        check("sub_const", 32'd2, 1'b0, 1'b0);
        step("and", 1'b0, 4'b0000, 32'd5, 32'd3);
        step("or",  1'b0, 4'b0001, 32'd5, 32'd3);
        step("xor", 1'b0, 4'b1101, 32'd5, 32'd3);
        step("slt0", 1'b0, 4'b0111, 32'd5, 32'd3);
        check("slt0_const", 32'd0, 1'b1, 1'b0);
        step("nor", 1'b0, 4'b1100, 32'd5, 32'd3);
        check("nor_const", 32'hFFFF_FFF8, 1'b0, 1'b0);

        step("slt_neg", 1'b0, 4'b0111, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg_const", 32'd1, 1'b0, 1'b0);
        step("sltu", 1'b0, 4'b1000, 32'hFFFF_FFFF, 32'd1);
        check("sltu_const", 32'd0, 1'b1, 1'b0);

        step("add_ovf", 1'b0, 4'b0010, 32'h7FFF_FFFF, 32'd1);
        check("add_ovf_const", 32'h8000_0000, 1'b0, 1'b1);
        step("sub_ovf", 1'b0, 4'b0110, 32'h8000_0000, 32'd1);
        check("sub_ovf_const", 32'h7FFF_FFFF, 1'b0, 1'b1);
        step("add_wrap", 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap_const", 32'd0, 1'b1, 1'b0);

        step("b2b_add", 1'b0, 4'b0010, 32'd10, 32'd20);
        step("b2b_rst", 1'b1, 4'b0110, 32'd10, 32'd20);
        step("b2b_or",  1'b0, 4'b0001, 32'hF0, 32'h0F);
        check("b2b_or_const", 32'hFF, 1'b0, 1'b0);

        step("sll", 1'b0, 4'b0011, 32'h8000_0010, 32'd4);
        step("srl", 1'b0, 4'b0100, 32'h8000_0010, 32'd4);
        step("sra", 1'b0, 4'b0101, 32'h8000_0010, 32'd4);
`ifdef MIPS_ALU_SHIFT_EN
        check("sra_const", 32'hF800_0001, 1'b0, 1'b0);
        step("sll0", 1'b0, 4'b0011, 32'h1234_5678, 32'd0);
`else
        check("sra_off_const", 32'd0, 1'b1, 1'b0);
`endif
        step("undef", 1'b0, 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom);
            case ($urandom_range(0, 3))
                0: begin ra = 32'h7FFF_FFFF - 32'($urandom_range(0, 3)); rb = 32'($urandom_range(0, 3)); end
                1: begin ra = 32'h8000_0000 + 32'($urandom_range(0, 3)); rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3)); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            step("rand", ($urandom_range(0, 19) == 0), rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
